// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI master: register map, STATUS/CTRL
// bit positions, serial-engine state encoding and the STATUS packing helper.
package sd_spi_pkg;

  localparam logic [3:0] SD_DATA   = 4'd0;
  localparam logic [3:0] SD_STATUS = 4'd1;
  localparam logic [3:0] SD_CTRL   = 4'd2;
  localparam logic [3:0] SD_DIV    = 4'd3;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_VALID = 2;
  localparam int STAT_BUSY     = 3;
  localparam int STAT_RXOVR    = 4;
  localparam int STAT_TXDROP   = 5;

  localparam int CTRL_CS_EN   = 0;
  localparam int CTRL_IE_RX   = 1;
  localparam int CTRL_IE_IDLE = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } spi_state_e;

  function automatic logic [7:0] pack_status(input logic tx_full, input logic tx_empty,
                                             input logic rx_valid, input logic busy,
                                             input logic rxovr, input logic txdrop);
    pack_status = {2'b00, txdrop, rxovr, busy, rx_valid, tx_empty, tx_full};
  endfunction

endpackage

// File: rtl/sd_spi_fifo.sv
// Synchronous byte FIFO with wrap-around pointers carrying an extra MSB so
// full and empty are told apart without a separate occupancy counter.
module spi_fifo
  import sd_spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign head      = mem_r[rd_ptr_r[AW-1:0]];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer update; a push into a full FIFO is simply not taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/sd_spi.sv
// Byte-oriented SPI master (mode 0) for an SD card on the io bus: TX/RX FIFOs,
// STATUS/CTRL/DIV registers and a LO/HI half-period serial engine.
module sd_spi
  import sd_spi_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] DIV_RESET = 8'h3f
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] io_addr,
  input  logic       io_write,
  input  logic       io_read,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic       interrupt,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  logic [2:0] ctrl_r;
  logic [7:0] div_r;
  logic       rxovr_r, txdrop_r, cs_n_r, interrupt_r;
  spi_state_e state_r, state_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic [3:0] bitcnt_r, bitcnt_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;
  logic       miso_bit_r, miso_bit_nxt_s;
  logic       sclk_r, sclk_nxt_s, mosi_r, mosi_nxt_s;
  logic       tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic [7:0] tx_head_s, rx_head_s, rx_byte_s;
  logic       tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic       busy_s, cnt_zero_s, last_bit_s, stat_wr_s;

  assign tx_push_s  = io_write & (io_addr == SD_DATA);
  assign tx_pop_s   = (state_r == S_IDLE) & ~tx_empty_s;
  assign rx_pop_s   = io_read & (io_addr == SD_DATA) & ~rx_empty_s;
  assign stat_wr_s  = io_write & (io_addr == SD_STATUS);
  assign busy_s     = (state_r != S_IDLE) | ~tx_empty_s;
  assign cnt_zero_s = (cnt_r == 8'd0);
  assign last_bit_s = (bitcnt_r == 4'd7);
  // The received bit of the current cycle sits in miso_bit_r until the next shift.
  assign rx_byte_s  = {shift_r[6:0], miso_bit_r};

  spi_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push_s), .din(io_wdata), .pop(tx_pop_s),
    .head(tx_head_s), .full(tx_full_s), .empty(tx_empty_s)
  );

  spi_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push_s), .din(rx_byte_s), .pop(rx_pop_s),
    .head(rx_head_s), .full(rx_full_s), .empty(rx_empty_s)
  );

  // CPU-visible control registers and sticky flags; a set beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_r   <= 3'd0;
      div_r    <= DIV_RESET;
      cs_n_r   <= 1'b1;
      rxovr_r  <= 1'b0;
      txdrop_r <= 1'b0;
    end else begin
      if (io_write && (io_addr == SD_CTRL)) begin
        ctrl_r <= io_wdata[2:0];
        cs_n_r <= ~io_wdata[CTRL_CS_EN];
      end
      if (io_write && (io_addr == SD_DIV)) begin
        div_r <= io_wdata;
      end
      if (rx_push_s && rx_full_s) begin
        rxovr_r <= 1'b1;
      end else if (stat_wr_s && io_wdata[STAT_RXOVR]) begin
        rxovr_r <= 1'b0;
      end
      if (tx_push_s && tx_full_s) begin
        txdrop_r <= 1'b1;
      end else if (stat_wr_s && io_wdata[STAT_TXDROP]) begin
        txdrop_r <= 1'b0;
      end
    end
  end

  // Serial engine state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Serial engine next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!tx_empty_s) state_nxt_s = S_LO;
        else             state_nxt_s = S_IDLE;
      end
      S_LO: begin
        if (cnt_zero_s) state_nxt_s = S_HI;
        else            state_nxt_s = S_LO;
      end
      S_HI: begin
        if (cnt_zero_s && last_bit_s)  state_nxt_s = S_IDLE;
        else if (cnt_zero_s)           state_nxt_s = S_LO;
        else                           state_nxt_s = S_HI;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Serial engine outputs: next values of the datapath registers and the RX push.
  always_comb begin
    cnt_nxt_s      = cnt_r;
    bitcnt_nxt_s   = bitcnt_r;
    shift_nxt_s    = shift_r;
    miso_bit_nxt_s = miso_bit_r;
    sclk_nxt_s     = sclk_r;
    mosi_nxt_s     = mosi_r;
    rx_push_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!tx_empty_s) begin
          shift_nxt_s  = tx_head_s;
          mosi_nxt_s   = tx_head_s[7];
          cnt_nxt_s    = div_r;
          bitcnt_nxt_s = 4'd0;
        end else begin
          mosi_nxt_s = 1'b1;
        end
      end
      S_LO: begin
        if (cnt_zero_s) begin
          sclk_nxt_s     = 1'b1;
          miso_bit_nxt_s = miso;
          cnt_nxt_s      = div_r;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      S_HI: begin
        if (cnt_zero_s && last_bit_s) begin
          sclk_nxt_s   = 1'b0;
          bitcnt_nxt_s = bitcnt_r + 4'd1;
          mosi_nxt_s   = 1'b1;
          rx_push_s    = 1'b1;
        end else if (cnt_zero_s) begin
          sclk_nxt_s   = 1'b0;
          bitcnt_nxt_s = bitcnt_r + 4'd1;
          shift_nxt_s  = rx_byte_s;
          mosi_nxt_s   = shift_r[6];
          cnt_nxt_s    = div_r;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      default: begin
        sclk_nxt_s = 1'b0;
        mosi_nxt_s = 1'b1;
      end
    endcase
  end

  // Serial engine datapath registers, including the sclk/mosi pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r      <= 8'd0;
      bitcnt_r   <= 4'd0;
      shift_r    <= 8'd0;
      miso_bit_r <= 1'b0;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b1;
    end else begin
      cnt_r      <= cnt_nxt_s;
      bitcnt_r   <= bitcnt_nxt_s;
      shift_r    <= shift_nxt_s;
      miso_bit_r <= miso_bit_nxt_s;
      sclk_r     <= sclk_nxt_s;
      mosi_r     <= mosi_nxt_s;
    end
  end

  // Level interrupt, registered one clock behind its sources.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      interrupt_r <= 1'b0;
    end else begin
      interrupt_r <= (ctrl_r[CTRL_IE_RX] & ~rx_empty_s) | (ctrl_r[CTRL_IE_IDLE] & ~busy_s);
    end
  end

  // Register read mux; unmapped indices read zero.
  always_comb begin
    io_rdata = 8'h00;
    case (io_addr)
      SD_DATA:   io_rdata = rx_empty_s ? 8'hff : rx_head_s;
      SD_STATUS: io_rdata = pack_status(tx_full_s, tx_empty_s, ~rx_empty_s, busy_s, rxovr_r, txdrop_r);
      SD_CTRL:   io_rdata = {5'b00000, ctrl_r};
      SD_DIV:    io_rdata = div_r;
      default:   io_rdata = 8'h00;
    endcase
  end

  assign sclk      = sclk_r;
  assign mosi      = mosi_r;
  assign cs_n      = cs_n_r;
  assign interrupt = interrupt_r;

endmodule

// File: tb/tb_sd_spi.sv
// Self-checking bench for sd_spi: directed scenarios plus random register
// traffic, compared against a transaction-level queue model of the peripheral.
module tb_sd_spi;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] io_addr = 4'd0;
  logic       io_write = 1'b0;
  logic       io_read = 1'b0;
  logic [7:0] io_wdata = 8'd0;
  logic [7:0] io_rdata;
  logic       interrupt, sclk, mosi, cs_n, miso;
  logic       loop_en = 1'b1;
  logic       miso_const = 1'b1;

  assign miso = loop_en ? mosi : miso_const;

  sd_spi #(.DEPTH(DEPTH), .DIV_RESET(8'h3f)) dut (
    .clk(clk), .reset(reset), .io_addr(io_addr), .io_write(io_write), .io_read(io_read),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .interrupt(interrupt), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  // Serial-line monitor: counts sclk rising edges and records mosi at each.
  int         sclk_rises = 0;
  logic [7:0] mosi_bits = 8'd0;
  always @(posedge sclk) begin
    sclk_rises <= sclk_rises + 1;
    mosi_bits  <= {mosi_bits[6:0], mosi};
  end

  // Reference model: byte queues, sticky flags and a byte-duration countdown.
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         m_rem;
  logic [7:0] m_cur, m_div;
  logic [2:0] m_ctrl;
  logic       m_ovr, m_drop, m_intr;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_rem  = 0;
    m_cur  = 8'd0;
    m_div  = 8'h3f;
    m_ctrl = 3'd0;
    m_ovr  = 1'b0;
    m_drop = 1'b0;
    m_intr = 1'b0;
  endtask

  function automatic logic model_busy();
    return (m_rem != 0) || (tx_q.size() != 0);
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] a);
    logic [7:0] v;
    case (a)
      4'd0: v = (rx_q.size() != 0) ? rx_q[0] : 8'hff;
      4'd1: v = {2'b00, m_drop, m_ovr, model_busy(), rx_q.size() != 0,
                 tx_q.size() == 0, tx_q.size() == DEPTH};
      4'd2: v = {5'b00000, m_ctrl};
      4'd3: v = m_div;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // One clock edge of the model, using the state from before the edge for every decision.
  task automatic model_edge(input bit wr, input bit rd, input logic [3:0] a, input logic [7:0] d);
    int         tx_n, rx_n;
    logic       intr_nxt, eng_pop, eng_done;
    logic [7:0] rx_byte;
    tx_n     = tx_q.size();
    rx_n     = rx_q.size();
    intr_nxt = (m_ctrl[1] && rx_n != 0) || (m_ctrl[2] && !model_busy());
    eng_pop  = (m_rem == 0) && (tx_n != 0);
    eng_done = (m_rem == 1);
    rx_byte  = loop_en ? m_cur : {8{miso_const}};
    if (eng_pop) begin
      m_cur = tx_q.pop_front();
      m_rem = 16 * (int'(m_div) + 1);
    end else if (m_rem != 0) begin
      m_rem--;
    end
    if (wr && a == 4'd0) begin
      if (tx_n == DEPTH) m_drop = 1'b1;
      else tx_q.push_back(d);
    end else if (wr && a == 4'd1 && d[5]) begin
      m_drop = 1'b0;
    end
    if (rd && a == 4'd0 && rx_n != 0) void'(rx_q.pop_front());
    if (eng_done && rx_n == DEPTH) m_ovr = 1'b1;
    else if (wr && a == 4'd1 && d[4]) m_ovr = 1'b0;
    if (eng_done && rx_n != DEPTH) rx_q.push_back(rx_byte);
    if (wr && a == 4'd2) m_ctrl = d[2:0];
    if (wr && a == 4'd3) m_div = d;
    m_intr = intr_nxt;
  endtask

  // One bus cycle: drive at the falling edge, check just after, clock, update the model.
  task automatic step(input bit wr, input bit rd, input logic [3:0] a, input logic [7:0] d,
                      output logic [7:0] q);
    io_write = wr;
    io_read  = rd;
    io_addr  = a;
    io_wdata = d;
    #1;
    q = io_rdata;
    check("intr", interrupt, m_intr);
    check("cs_n", cs_n, !m_ctrl[0]);
    if (rd) check($sformatf("rd%0d", a), io_rdata, model_read(a));
    @(posedge clk);
    model_edge(wr, rd, a, d);
    @(negedge clk);
    io_write = 1'b0;
    io_read  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] q;
    step(1'b1, 1'b0, a, d, q);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] q);
    step(1'b0, 1'b1, a, 8'd0, q);
  endtask

  task automatic idle(input int n);
    logic [7:0] q;
    repeat (n) step(1'b0, 1'b0, 4'd0, 8'd0, q);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  logic [7:0] q;
  int         base;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b1);
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_intr", interrupt, 1'b0);
    rd(4'd1, q); check("rst_status", q, 8'h02);
    rd(4'd3, q); check("rst_div", q, 8'h3f);
    rd(4'd0, q); check("rst_data", q, 8'hff);

    // Loopback byte at DIV=0.
    wr(4'd2, 8'h01);
    wr(4'd3, 8'h00);
    loop_en = 1'b1;
    base = sclk_rises;
    wr(4'd0, 8'ha5);
    repeat (20) rd(4'd1, q);
    check("a5_pulses", sclk_rises - base, 8);
    check("a5_mosi", mosi_bits, 8'ha5);
    rd(4'd0, q); check("a5_data", q, 8'ha5);
    rd(4'd0, q); check("a5_empty", q, 8'hff);

    // TX full and drop at DIV=3.
    wr(4'd3, 8'h03);
    for (int i = 0; i < 5; i++) wr(4'd0, 8'(8'h10 + i));
    wr(4'd0, 8'h99);
    rd(4'd1, q); check("txdrop_set", q[5], 1'b1);
    wr(4'd1, 8'h20);
    rd(4'd1, q); check("txdrop_clr", q[5], 1'b0);
    idle(400);
    for (int i = 0; i < 4; i++) rd(4'd0, q);
    wr(4'd1, 8'h30);

    // RX overflow with miso held high.
    wr(4'd3, 8'h00);
    loop_en = 1'b0;
    miso_const = 1'b1;
    for (int i = 0; i < 5; i++) wr(4'd0, 8'($urandom));
    idle(100);
    rd(4'd1, q); check("rxovr_set", q[4], 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd(4'd0, q); check("ovr_byte", q, 8'hff);
    end
    rd(4'd0, q); check("ovr_empty", q, 8'hff);
    rd(4'd1, q); check("ovr_rx_valid", q[2], 1'b0);
    wr(4'd1, 8'h30);

    // Idle and RX interrupt enables.
    loop_en = 1'b1;
    wr(4'd2, 8'h04);
    idle(2);
    check("ie_idle_hi", interrupt, 1'b1);
    wr(4'd0, 8'h3c);
    idle(1);
    check("ie_idle_busy", interrupt, 1'b0);
    idle(24);
    wr(4'd2, 8'h02);
    wr(4'd0, 8'h5a);
    idle(25);
    check("ie_rx_hi", interrupt, 1'b1);
    rd(4'd0, q);
    rd(4'd0, q);
    wr(4'd2, 8'h00);
    idle(2);

    // Reset in the middle of bit 4 at DIV=2.
    wr(4'd2, 8'h01);
    wr(4'd3, 8'h02);
    wr(4'd0, 8'hc3);
    idle(27);
    reset = 1'b1;
    #1;
    check("mid_rst_sclk", sclk, 1'b0);
    check("mid_rst_mosi", mosi, 1'b1);
    check("mid_rst_cs_n", cs_n, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd(4'd1, q); check("post_rst_status", q, 8'h02);
    rd(4'd0, q); check("post_rst_data", q, 8'hff);
    idle(40);
    rd(4'd1, q); check("post_rst_quiet", q, 8'h02);

    // Random register traffic with loopback data.
    wr(4'd3, 8'($urandom_range(0, 2)));
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: idle(1);
        3, 4:    wr(4'd0, 8'($urandom));
        5, 6:    rd(4'd0, q);
        7:       rd(4'($urandom_range(1, 15)), q);
        8:       wr(4'd1, 8'($urandom));
        default: begin
          if ($urandom_range(0, 1) == 0) wr(4'd2, 8'($urandom));
          else wr(4'($urandom_range(4, 15)), 8'($urandom));
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
